// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C register-window target: FSM state encoding
// and the bit-counter width.
package i2c_target_regs_pkg;

   localparam int BCNT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_AACK   = 3'd2,
      S_WPTR   = 3'd3,
      S_WDATA  = 3'd4,
      S_RDATA  = 3'd5,
      S_IGNORE = 3'd6
   } state_t;

endpackage

// File: rtl/i2c_target_regs_in_filter.sv
// Pad conditioning for one I2C line: 2-FF synchronizer, FILT-cycle stability
// filter and registered rise/fall pulses on the filtered value.
module i2c_in_filter #(
   parameter int FILT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic filt,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(FILT + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // Idle bus level is high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
         filt <= 1'b1;
         cnt  <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILT - 1)) begin
            filt <= sync[1];
            cnt  <= '0;
            rise <= sync[1];
            fall <= ~sync[1];
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register window: pointer byte first, then
// auto-incrementing writes or reads. No clock stretching.
module i2c_target_regs
   import i2c_target_regs_pkg::*;
#(
   parameter logic [6:0] ADDR = 7'h42,
   parameter int         FILT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   logic scl_f, scl_rise, scl_fall;
   logic sda_f, sda_rise, sda_fall;

   i2c_in_filter #(.FILT(FILT)) u_scl (
      .clk(clk), .rst_n(rst_n), .raw(scl_i),
      .filt(scl_f), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_in_filter #(.FILT(FILT)) u_sda (
      .clk(clk), .rst_n(rst_n), .raw(sda_i),
      .filt(sda_f), .rise(sda_rise), .fall(sda_fall)
   );

   state_t            state, state_nx;
   logic [BCNT_W-1:0] bit_cnt;
   logic              byte_done, ack_ph, rw, re_d;
   logic [7:0]        shreg;
   logic [7:0]        byte_in;
   logic              start_c, stop_c, data_rise, last_rise, rd_fall;

   assign start_c   = sda_fall & scl_f;
   assign stop_c    = sda_rise & scl_f;
   assign byte_in   = {shreg[6:0], sda_f};
   assign data_rise = scl_rise & ~ack_ph &
                      (state inside {S_ADDR, S_WPTR, S_WDATA, S_RDATA});
   assign last_rise = data_rise & (&bit_cnt);
   assign rd_fall   = scl_fall & ~ack_ph & ~byte_done & (state == S_RDATA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (stop_c) begin
         state_nx = S_IDLE;
      end else if (start_c) begin
         state_nx = S_ADDR;
      end else begin
         case (state)
            S_ADDR:  if (last_rise)
                        state_nx = (byte_in[7:1] == ADDR) ? S_AACK : S_IGNORE;
            S_AACK:  if (scl_fall && ack_ph) state_nx = rw ? S_RDATA : S_WPTR;
            S_WPTR:  if (scl_fall && ack_ph) state_nx = S_WDATA;
            S_RDATA: if (scl_rise && ack_ph && sda_f) state_nx = S_IGNORE;
            default: ;
         endcase
      end
   end

   // byte_done marks the 8th rise -> 8th fall gap; ack_ph spans the 9th clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         byte_done <= 1'b0;
         ack_ph    <= 1'b0;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         reg_addr  <= 8'h00;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         re_d      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         reg_re <= 1'b0;
         re_d   <= reg_re;
         if (reg_we) reg_addr <= reg_addr + 8'h01;
         if (stop_c || start_c) begin
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            ack_ph    <= 1'b0;
            sda_oe    <= 1'b0;
            if (stop_c) busy <= 1'b0;
         end else begin
            if (data_rise) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (&bit_cnt) begin
                  byte_done <= 1'b1;
                  case (state)
                     S_ADDR: begin
                        rw <= sda_f;
                        if (byte_in[7:1] == ADDR) busy <= 1'b1;
                     end
                     S_WPTR:  reg_addr <= byte_in;
                     S_WDATA: begin
                        reg_wdata <= byte_in;
                        reg_we    <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            if (scl_fall && byte_done) begin
               byte_done <= 1'b0;
               ack_ph    <= 1'b1;
               sda_oe    <= state inside {S_AACK, S_WPTR, S_WDATA};
            end
            if (scl_rise && ack_ph) begin
               if (state == S_AACK && rw) reg_re <= 1'b1;
               if (state == S_RDATA && !sda_f) begin
                  reg_addr <= reg_addr + 8'h01;
                  reg_re   <= 1'b1;
               end
            end
            if (scl_fall && ack_ph) begin
               ack_ph  <= 1'b0;
               bit_cnt <= '0;
               sda_oe  <= ((state == S_AACK && rw) || state == S_RDATA) ? ~shreg[7] : 1'b0;
            end
            if (rd_fall) sda_oe <= ~shreg[6];
         end
      end
   end

   // Read data lands one clk after reg_re, well before the ACK-slot scl fall.
   always_ff @(posedge clk) begin
      if (re_d)
         shreg <= reg_rdata;
      else if (data_rise && state != S_RDATA)
         shreg <= byte_in;
      else if (rd_fall)
         shreg <= {shreg[6:0], 1'b0};
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged open-drain master plus a
// small register memory answering reg_re.
module tb_i2c_target_regs;

   localparam int Q = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_oe, reg_we, reg_re, busy;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       sda_line;

   logic [7:0] mem [256];
   logic [7:0] we_a [$];
   logic [7:0] we_d [$];
   logic [7:0] re_a [$];
   int         checks = 0;
   int         errors = 0;
   int         oe_cnt = 0;
   int         both_cnt = 0;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_regs #(.ADDR(7'h42), .FILT(3)) dut (
      .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line),
      .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reg_re) begin
         reg_rdata <= mem[reg_addr];
         re_a.push_back(reg_addr);
      end
      if (reg_we) begin
         we_a.push_back(reg_addr);
         we_d.push_back(reg_wdata);
      end
      if (sda_oe) oe_cnt <= oe_cnt + 1;
      if (reg_we && reg_re) both_cnt <= both_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_cond();
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic stop_cond();
      sda_m = 1'b0; tick(Q);
      scl_m = 1'b1; tick(Q);
      sda_m = 1'b1; tick(2 * Q);
   endtask

   task automatic bit_x(input logic b, output logic s);
      sda_m = b;    tick(Q);
      scl_m = 1'b1; tick(Q);
      s = sda_line; tick(Q);
      scl_m = 1'b0; tick(Q);
   endtask

   task automatic wbyte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_x(d[i], s);
      bit_x(1'b1, s);
      ack = ~s;
   endtask

   task automatic rbyte(input logic ackm, output logic [7:0] d);
      logic s;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bit_x(1'b1, s);
         d = {d[6:0], s};
      end
      bit_x(~ackm, s);
   endtask

   initial begin
      logic       a;
      logic [7:0] rd;
      int         n0;
      logic       s;

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h20] = 8'h3C;
      mem[8'h21] = 8'hA5;
      mem[8'h40] = 8'h00;

      tick(3);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_we", reg_we, 0);
      chk("rst_re", reg_re, 0);
      chk("rst_addr", reg_addr, 8'h00);
      chk("rst_wdata", reg_wdata, 8'h00);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick(Q);

      // Write pointer 0x10, then two data bytes
      start_cond();
      wbyte(8'h84, a); chk("t1_aack", a, 1);
      chk("t1_busy", busy, 1);
      wbyte(8'h10, a); chk("t1_pack", a, 1);
      wbyte(8'hAA, a); chk("t1_d0ack", a, 1);
      wbyte(8'h55, a); chk("t1_d1ack", a, 1);
      stop_cond();
      tick(5);
      chk("t1_we_n", we_a.size(), 2);
      chk("t1_we0_a", we_a[0], 8'h10);
      chk("t1_we0_d", we_d[0], 8'hAA);
      chk("t1_we1_a", we_a[1], 8'h11);
      chk("t1_we1_d", we_d[1], 8'h55);
      chk("t1_addr", reg_addr, 8'h12);
      chk("t1_busy_off", busy, 0);

      // Pointer 0x20, repeated START, read two bytes
      start_cond();
      wbyte(8'h84, a); chk("t2_aack", a, 1);
      wbyte(8'h20, a); chk("t2_pack", a, 1);
      start_cond();
      wbyte(8'h85, a); chk("t2_raack", a, 1);
      rbyte(1'b1, rd); chk("t2_rd0", rd, 8'h3C);
      rbyte(1'b0, rd); chk("t2_rd1", rd, 8'hA5);
      tick(2);
      chk("t2_release", sda_oe, 0);
      chk("t2_busy", busy, 1);
      stop_cond();
      tick(5);
      chk("t2_re_n", re_a.size(), 2);
      chk("t2_re0", re_a[0], 8'h20);
      chk("t2_re1", re_a[1], 8'h21);
      chk("t2_we_n", we_a.size(), 2);
      chk("t2_busy_off", busy, 0);

      // Foreign address 0x43
      n0 = oe_cnt;
      start_cond();
      wbyte(8'h86, a); chk("t3_noack", a, 0);
      chk("t3_busy", busy, 0);
      chk("t3_oe_quiet", oe_cnt - n0, 0);
      stop_cond();
      tick(5);
      chk("t3_we_n", we_a.size(), 2);
      chk("t3_re_n", re_a.size(), 2);

      // Pointer wrap 0xFF -> 0x00
      start_cond();
      wbyte(8'h84, a); chk("t4_aack", a, 1);
      wbyte(8'hFF, a); chk("t4_pack", a, 1);
      wbyte(8'h01, a); chk("t4_d0ack", a, 1);
      wbyte(8'h02, a); chk("t4_d1ack", a, 1);
      wbyte(8'h03, a); chk("t4_d2ack", a, 1);
      stop_cond();
      tick(5);
      chk("t4_we_n", we_a.size(), 5);
      chk("t4_we2_a", we_a[2], 8'hFF);
      chk("t4_we3_a", we_a[3], 8'h00);
      chk("t4_we4_a", we_a[4], 8'h01);
      chk("t4_we4_d", we_d[4], 8'h03);
      chk("t4_addr", reg_addr, 8'h02);

      // STOP after 4 data bits aborts the byte
      start_cond();
      wbyte(8'h84, a); chk("t5_aack", a, 1);
      wbyte(8'h30, a); chk("t5_pack", a, 1);
      bit_x(1'b1, s); bit_x(1'b0, s); bit_x(1'b1, s); bit_x(1'b1, s);
      stop_cond();
      tick(5);
      chk("t5_we_n", we_a.size(), 5);
      chk("t5_addr", reg_addr, 8'h30);
      chk("t5_oe", sda_oe, 0);
      chk("t5_busy", busy, 0);

      // 1-clk SDA glitch with SCL high must not look like a START
      sda_m = 1'b0; tick(1);
      sda_m = 1'b1; tick(Q);
      scl_m = 1'b0; tick(Q);
      n0 = oe_cnt;
      wbyte(8'h84, a); chk("t5_glitch_noack", a, 0);
      chk("t5_glitch_oe", oe_cnt - n0, 0);
      chk("t5_glitch_busy", busy, 0);
      stop_cond();

      // Async reset while the target drives a 0 data bit
      start_cond();
      wbyte(8'h84, a); chk("t6_aack", a, 1);
      wbyte(8'h40, a); chk("t6_pack", a, 1);
      start_cond();
      wbyte(8'h85, a); chk("t6_raack", a, 1);
      chk("t6_drive0", sda_oe, 1);
      rst_n = 1'b0;
      tick(1);
      chk("t6_rst_oe", sda_oe, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_addr", reg_addr, 8'h00);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      scl_m = 1'b1; tick(Q);
      start_cond();
      wbyte(8'h84, a); chk("t6_post_aack", a, 1);
      chk("t6_post_busy", busy, 1);
      stop_cond();
      tick(5);
      chk("t6_post_busy_off", busy, 0);

      chk("we_re_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
